// File: rtl/acc_datapath.sv
// Averaging datapath: captures memory words, accumulates groups of eight with
// saturation, commits group averages into a four-entry result bank.
module acc_datapath #(
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Load,
    input  logic              Transfer,
    input  logic              Clear,
    input  logic              WriteEnable,
    input  logic              Ready,
    input  logic [1:0]        ResultSel,
    output logic [DATA_W-1:0] DataOut,
    output logic [DATA_W+2:0] Sum,
    output logic [3:0]        SampleCount,
    output logic [DATA_W-1:0] ResultOut,
    output logic [2:0]        ResultCount,
    output logic              Done,
    output logic              Error
);

    localparam int ACC_W   = DATA_W + 3;
    localparam int GROUP_N = 8;
    localparam int BANK_N  = 4;

    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        rc_q, rc_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] bank_q [BANK_N];
    logic [DATA_W-1:0] bank_d [BANK_N];
    logic [ACC_W:0]    acc_raw;

    // Carry out of the extended sum marks overflow; clamp to all ones.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] raw);
        if (raw[ACC_W]) return {ACC_W{1'b1}};
        return raw[ACC_W-1:0];
    endfunction

    assign acc_raw = {1'b0, acc_q} + (ACC_W+1)'(opnd_q);

    always_comb begin
        opnd_d = opnd_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        rc_d   = rc_q;
        done_d = done_q;
        err_d  = err_q;
        bank_d = bank_q;

        if (Load) opnd_d = DataIn;

        // Clear is active-low and beats a simultaneous Transfer.
        if (!Clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (Transfer) begin
            acc_d = sat_acc(acc_raw);
            if (cnt_q != 4'(GROUP_N)) cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(GROUP_N) || acc_raw[ACC_W]) err_d = 1'b1;
        end

        if (WriteEnable) begin
            if (cnt_q != 4'(GROUP_N) || rc_q == 3'(BANK_N)) err_d = 1'b1;
            if (rc_q < 3'(BANK_N)) begin
                bank_d[rc_q[1:0]] = DataOut;
                rc_d              = rc_q + 3'd1;
            end
        end

        // Clear-low after a finished run restarts the result sequence.
        if (!Clear && done_q) begin
            done_d = 1'b0;
            rc_d   = '0;
        end else if (Ready) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            opnd_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            rc_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            bank_q <= '{default: '0};
        end else begin
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            rc_q   <= rc_d;
            done_q <= done_d;
            err_q  <= err_d;
            bank_q <= bank_d;
        end
    end

    assign DataOut     = acc_q[ACC_W-1:3];
    assign Sum         = acc_q;
    assign SampleCount = cnt_q;
    assign ResultOut   = bank_q[ResultSel];
    assign ResultCount = rc_q;
    assign Done        = done_q;
    assign Error       = err_q;

endmodule

// File: tb/tb_acc_datapath.sv
// Scoreboard bench for acc_datapath: an integer reference model predicts the
// state after every driven edge; a monitor compares it one step after the edge.
module tb_acc_datapath;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] DataIn = '0;
    logic       Load = 1'b0, Transfer = 1'b0, Clear = 1'b1;
    logic       WriteEnable = 1'b0, Ready = 1'b0;
    logic [1:0] ResultSel = '0;
    logic [7:0] DataOut;
    logic [10:0] Sum;
    logic [3:0] SampleCount;
    logic [7:0] ResultOut;
    logic [2:0] ResultCount;
    logic       Done, Error;

    acc_datapath #(.DATA_W(8)) dut (
        .Clock(clk), .Reset(Reset), .DataIn(DataIn), .Load(Load),
        .Transfer(Transfer), .Clear(Clear), .WriteEnable(WriteEnable),
        .Ready(Ready), .ResultSel(ResultSel), .DataOut(DataOut), .Sum(Sum),
        .SampleCount(SampleCount), .ResultOut(ResultOut),
        .ResultCount(ResultCount), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum; int dout; int cnt; int rc; int done; int err; int rout;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference state, plain integers
    int m_acc = 0, m_cnt = 0, m_opnd = 0, m_rc = 0, m_done = 0, m_err = 0;
    int m_bank [4] = '{0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit ld, input bit tr, input bit clr_n,
                              input bit we, input bit rdy, input int din, input int sel);
        int s;
        int o_acc, o_cnt, o_rc, o_opnd, o_done;
        exp_t e;
        o_acc = m_acc; o_cnt = m_cnt; o_rc = m_rc; o_opnd = m_opnd; o_done = m_done;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_opnd = 0; m_rc = 0; m_done = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_bank[i] = 0;
        end else begin
            if (ld) m_opnd = din;
            if (!clr_n) begin
                m_acc = 0; m_cnt = 0;
            end else if (tr) begin
                s = o_acc + o_opnd;
                if (s > 2047 || o_cnt == 8) m_err = 1;
                m_acc = (s > 2047) ? 2047 : s;
                m_cnt = (o_cnt == 8) ? 8 : o_cnt + 1;
            end
            if (we) begin
                if (o_cnt != 8 || o_rc == 4) m_err = 1;
                if (o_rc < 4) begin
                    m_bank[o_rc] = o_acc / 8;
                    m_rc = o_rc + 1;
                end
            end
            if (!clr_n && o_done == 1) begin
                m_done = 0; m_rc = 0;
            end else if (rdy) begin
                m_done = 1;
            end
        end
        e.sum = m_acc; e.dout = m_acc / 8; e.cnt = m_cnt; e.rc = m_rc;
        e.done = m_done; e.err = m_err; e.rout = m_bank[sel];
        exp_q.push_back(e);
    endtask

    // One driven edge: inputs applied on the falling edge, strobes dropped after.
    task automatic cyc(input bit rst, input bit ld, input bit tr, input bit clr_n,
                       input bit we, input bit rdy, input int din, input int sel);
        @(negedge clk);
        Reset = rst; Load = ld; Transfer = tr; Clear = clr_n;
        WriteEnable = we; Ready = rdy; DataIn = 8'(din); ResultSel = 2'(sel);
        model_step(rst, ld, tr, clr_n, we, rdy, din, sel);
        @(posedge clk);
        #1;
        Reset = 1'b0; Load = 1'b0; Transfer = 1'b0; Clear = 1'b1;
        WriteEnable = 1'b0; Ready = 1'b0;
    endtask

    task automatic do_reset();             cyc(1, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_idle(input int sel); cyc(0, 0, 0, 1, 0, 0, 0, sel); endtask
    task automatic do_load_xfer(input int d);
        cyc(0, 1, 0, 1, 0, 0, d, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    // Monitor: every driven edge has exactly one expected entry queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sum", int'(Sum), e.sum);
                chk("data_out", int'(DataOut), e.dout);
                chk("sample_count", int'(SampleCount), e.cnt);
                chk("result_count", int'(ResultCount), e.rc);
                chk("done", int'(Done), e.done);
                chk("error", int'(Error), e.err);
                chk("result_out", int'(ResultOut), e.rout);
            end
        end
    end

    initial begin
        int bound;
        int grp_avg [4] = '{3, 11, 19, 27};

        // Reset state
        do_reset();
        chk("rst_sum", int'(Sum), 0);
        chk("rst_dout", int'(DataOut), 0);
        chk("rst_rout", int'(ResultOut), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_err", int'(Error), 0);

        // Group sum of eight tens, then commit
        for (int i = 0; i < 8; i++) do_load_xfer(10);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        chk("grp_sum", int'(Sum), 80);
        chk("grp_dout", int'(DataOut), 10);
        chk("grp_bank0", int'(ResultOut), 10);
        chk("grp_rc", int'(ResultCount), 1);
        chk("grp_err", int'(Error), 0);

        // Saturation boundary
        do_reset();
        for (int i = 0; i < 8; i++) do_load_xfer(255);
        chk("sat_sum8", int'(Sum), 2040);
        chk("sat_dout8", int'(DataOut), 255);
        chk("sat_err8", int'(Error), 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        chk("sat_sum9", int'(Sum), 2047);
        chk("sat_cnt9", int'(SampleCount), 8);
        chk("sat_err9", int'(Error), 1);

        // Clear precedence over Transfer; also Load+Transfer same cycle
        do_reset();
        cyc(0, 1, 0, 1, 0, 0, 40, 0);
        cyc(0, 1, 1, 1, 0, 0, 5, 0);
        chk("lt_sum", int'(Sum), 40);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("clr_sum", int'(Sum), 0);
        chk("clr_cnt", int'(SampleCount), 0);

        // Full run over words 0..31
        do_reset();
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 8; k++) do_load_xfer(g * 8 + k);
            cyc(0, 0, 0, 1, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        chk("run_rc", int'(ResultCount), 4);
        chk("run_done", int'(Done), 1);
        chk("run_err", int'(Error), 0);
        for (int i = 0; i < 4; i++) begin
            do_idle(i);
            chk("run_bank", int'(ResultOut), grp_avg[i]);
        end

        // Over-commit leaves the bank alone and flags an error
        for (int i = 0; i < 8; i++) do_load_xfer(200);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        chk("ovc_err", int'(Error), 1);
        chk("ovc_rc", int'(ResultCount), 4);
        for (int i = 0; i < 4; i++) begin
            do_idle(i);
            chk("ovc_bank", int'(ResultOut), grp_avg[i]);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 2);
        chk("new_run_rc", int'(ResultCount), 0);
        chk("new_run_done", int'(Done), 0);
        chk("new_run_bank2", int'(ResultOut), 19);

        // Reset mid-group
        do_reset();
        for (int i = 0; i < 5; i++) do_load_xfer(7);
        do_reset();
        chk("mid_sum", int'(Sum), 0);
        chk("mid_cnt", int'(SampleCount), 0);
        chk("mid_rout", int'(ResultOut), 0);
        for (int i = 0; i < 8; i++) do_load_xfer(7);
        chk("mid_sum8", int'(Sum), 56);
        chk("mid_dout8", int'(DataOut), 7);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                !(r >= 1 && r <= 6), $urandom_range(0, 15) == 0,
                $urandom_range(0, 31) == 0, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)));
        end

        bound = 0;
        while (exp_q.size() > 0 && bound < 20) begin
            @(posedge clk);
            bound++;
        end
        #2;
        if (exp_q.size() > 0) chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
